// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key two-flop synchroniser, debounce filter and
// press / release / long-hold pulse generation, all outputs registered.
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_down,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_hold
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  // Last count before the new level is accepted; hold fires one step before saturation.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } state_t;

  logic [N_KEYS-1:0] meta;
  logic [N_KEYS-1:0] stable;
  logic [N_KEYS-1:0] sync;
  logic [N_KEYS-1:0] accept;
  logic [DB_W-1:0]   db_cnt   [N_KEYS];
  logic [HOLD_W-1:0] hold_cnt [N_KEYS];
  state_t            state    [N_KEYS];

  assign sync = ~stable;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      accept[i] = (sync[i] != key_down[i]) && (db_cnt[i] == DB_LAST);
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      meta        <= '1;
      stable      <= '1;
      key_down    <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_hold    <= '0;
      // NOTE: these per-channel arrays are plain registers, not RAM, so resetting them is legal and intended.
      for (int i = 0; i < N_KEYS; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
        state[i]    <= RELEASED;
      end
    end else begin
      meta        <= KEY;
      stable      <= meta;
      key_press   <= '0;
      key_release <= '0;
      key_hold    <= '0;

      for (int i = 0; i < N_KEYS; i++) begin
        if (accept[i] || (sync[i] == key_down[i])) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end

        case (state[i])
          RELEASED: begin
            hold_cnt[i] <= '0;
            if (accept[i]) begin
              state[i]     <= PRESSED;
              key_down[i]  <= 1'b1;
              key_press[i] <= 1'b1;
            end
          end
          PRESSED: begin
            // Release wins over hold so the two pulses can never share a cycle.
            if (accept[i]) begin
              state[i]       <= RELEASED;
              key_down[i]    <= 1'b0;
              key_release[i] <= 1'b1;
              hold_cnt[i]    <= '0;
            end else if (hold_cnt[i] == HOLD_LAST) begin
              state[i]    <= HELD;
              key_hold[i] <= 1'b1;
              hold_cnt[i] <= HOLD_MAX;
            end else begin
              hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
          end
          HELD: begin
            if (accept[i]) begin
              state[i]       <= RELEASED;
              key_down[i]    <= 1'b0;
              key_release[i] <= 1'b1;
              hold_cnt[i]    <= '0;
            end
          end
          default: begin
            state[i]    <= RELEASED;
            key_down[i] <= 1'b0;
            hold_cnt[i] <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10;
// expected values are hand-derived edge counts from the moment KEY changes.
module tb_key_conditioner;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int HC = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] key = 4'b1111;
  logic [N-1:0] key_down;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_hold;

  int total = 0;
  int bad   = 0;
  int np [N];
  int nr [N];
  int nh [N];

  key_conditioner #(
    .N_KEYS         (N),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .KEY        (key),
    .key_down   (key_down),
    .key_press  (key_press),
    .key_release(key_release),
    .key_hold   (key_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < N; i++) begin
      np[i] = 0;
      nr[i] = 0;
      nh[i] = 0;
    end
  endtask

  // One rising edge, then sample 1 time unit later and tally pulses.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      np[i] += int'(key_press[i]);
      nr[i] += int'(key_release[i]);
      nh[i] += int'(key_hold[i]);
    end
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    clear_counts();

    // Reset values
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("reset_outs", {key_down, key_press, key_release, key_hold}, 32'h0);
    end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      check("idle_outs", {key_down, key_press, key_release, key_hold}, 32'h0);
    end

    // Clean press / release on KEY[0]
    clear_counts();
    key = 4'b1110;
    settle(5);
    check("clean_pre_down", key_down, 4'b0000);
    cyc();
    check("clean_down", key_down, 4'b0001);
    check("clean_press", key_press, 4'b0001);
    cyc();
    check("clean_press_width", key_press, 4'b0000);
    settle(2);
    key = 4'b1111;
    settle(5);
    check("clean_pre_release", key_down, 4'b0001);
    cyc();
    check("clean_up", key_down, 4'b0000);
    check("clean_release", key_release, 4'b0001);
    cyc();
    check("clean_release_width", key_release, 4'b0000);
    check("clean_press_count", np[0], 1);
    check("clean_hold_count", nh[0], 0);

    // Bounce rejection on KEY[1]
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      key = (k % 2 == 0) ? 4'b1101 : 4'b1111;
      settle(2);
    end
    check("bounce_press_count", np[1], 0);
    check("bounce_release_count", nr[1], 0);
    check("bounce_down", key_down, 4'b0000);
    key = 4'b1101;
    settle(5);
    check("bounce_pre_press", key_press, 4'b0000);
    cyc();
    check("bounce_press", key_press, 4'b0010);
    check("bounce_down_after", key_down, 4'b0010);
    key = 4'b1111;
    settle(12);
    check("bounce_total_press", np[1], 1);
    check("bounce_total_release", nr[1], 1);
    check("bounce_no_hold", nh[1], 0);

    // Long press on KEY[2]
    clear_counts();
    key = 4'b1011;
    settle(6);
    check("long_press", key_press, 4'b0100);
    settle(9);
    check("long_pre_hold", key_hold, 4'b0000);
    cyc();
    check("long_hold", key_hold, 4'b0100);
    settle(24);
    check("long_press_count", np[2], 1);
    check("long_hold_count", nh[2], 1);
    key = 4'b1111;
    settle(12);
    check("long_release_count", nr[2], 1);
    check("long_hold_after_release", nh[2], 1);
    check("long_down_after", key_down, 4'b0000);

    // Independence: keys 0 and 3 together, 3-cycle glitch on key 1
    clear_counts();
    key = 4'b0100;
    settle(3);
    key = 4'b0110;
    settle(2);
    check("indep_pre_press", key_press, 4'b0000);
    cyc();
    check("indep_press", key_press, 4'b1001);
    check("indep_down", key_down, 4'b1001);
    settle(2);
    key = 4'b1111;
    settle(12);
    check("indep_glitch_press", np[1], 0);
    check("indep_release_0", nr[0], 1);
    check("indep_release_3", nr[3], 1);
    check("indep_no_hold", nh[0] + nh[3], 0);

    // Reset while KEY[2] is in HELD
    clear_counts();
    key = 4'b1011;
    settle(16);
    check("midhold_held_fired", nh[2], 1);
    check("midhold_down", key_down, 4'b0100);
    clear_counts();
    reset = 1'b1;
    cyc();
    check("midhold_reset_outs", {key_down, key_press, key_release, key_hold}, 32'h0);
    reset = 1'b0;
    settle(5);
    check("midhold_pre_press", key_down, 4'b0000);
    cyc();
    check("midhold_repress", key_press, 4'b0100);
    settle(9);
    check("midhold_pre_hold", key_hold, 4'b0000);
    cyc();
    check("midhold_hold", key_hold, 4'b0100);
    check("midhold_no_release", nr[2], 0);
    key = 4'b1111;
    settle(12);
    check("midhold_final_release", nr[2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
